// File: rtl/loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | loader_pkg                                                           |
// | Command codes, FSM state encoding and halt marker for the loader.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package loader_pkg;

    localparam logic [7:0]  c_CMD_LOAD  = 8'h01;
    localparam logic [7:0]  c_CMD_RUN   = 8'h02;
    localparam logic [7:0]  c_CMD_STEP  = 8'h03;
    localparam logic [31:0] c_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_RUN  = 3'd3,
        ST_STEP = 3'd4,
        ST_DONE = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | word_assembler                                                       |
// | Shifts bytes in MSB first and flags the byte that completes a word.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module word_assembler #(
    parameter int LENGTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic [LENGTH-1:0] word,
    output logic              word_valid
);

    localparam int                 c_BYTES = LENGTH / 8;
    localparam int                 c_CNT_W = $clog2(c_BYTES);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_BYTES - 1);

    logic [LENGTH-9:0]  r_shift;
    logic [c_CNT_W-1:0] r_count;

    // Word and strobe are combinational so the caller can register the write
    // on the same edge that samples the final byte.
    assign word       = {r_shift, byte_in};
    assign word_valid = byte_valid && (r_count == c_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (byte_valid) begin
            r_shift <= word[LENGTH-9:0];
            r_count <= r_count + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/instruction_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_loader                                                   |
// | UART-fed program loader and run/step sequencer for instruction_fetch.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module instruction_loader
    import loader_pkg::*;
#(
    parameter int                LENGTH    = 32,
    parameter int                MEM_DEPTH = 256,
    parameter logic [LENGTH-1:0] HALT_WORD = c_HALT_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              halt_detected,
    output logic              write_enable,
    output logic [LENGTH-1:0] address_to_write,
    output logic [LENGTH-1:0] instruction_to_write,
    output logic              start,
    output logic              mips_enable,
    output logic              loaded,
    output logic              error,
    output logic [2:0]        state
);

    localparam logic [LENGTH-1:0] c_LAST_ADDR = LENGTH'(MEM_DEPTH - 1);

    state_t            r_state, w_state_next;
    logic [LENGTH-1:0] r_addr, w_addr_next;
    logic              r_we, w_we_next;
    logic [LENGTH-1:0] r_wr_addr, w_wr_addr_next;
    logic [LENGTH-1:0] r_wr_data, w_wr_data_next;
    logic              r_start, w_start_next;
    logic              r_mips, w_mips_next;
    logic              r_loaded, w_loaded_next;
    logic              r_error, w_error_next;

    logic              w_clear;
    logic              w_byte_valid;
    logic [LENGTH-1:0] w_word;
    logic              w_word_valid;

    // Only bytes arriving while in LOAD are program data.
    assign w_byte_valid = rx_valid && (r_state == ST_LOAD);

    word_assembler #(
        .LENGTH (LENGTH)
    ) u_word_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (w_clear),
        .byte_in    (rx_data),
        .byte_valid (w_byte_valid),
        .word       (w_word),
        .word_valid (w_word_valid)
    );

    always_comb begin
        w_state_next   = r_state;
        w_addr_next    = r_addr;
        w_we_next      = 1'b0;
        w_wr_addr_next = r_wr_addr;
        w_wr_data_next = r_wr_data;
        w_start_next   = 1'b0;
        w_mips_next    = 1'b0;
        w_loaded_next  = r_loaded;
        w_error_next   = r_error;
        w_clear        = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (rx_valid) begin
                    if (rx_data == c_CMD_LOAD) begin
                        w_state_next  = ST_LOAD;
                        w_error_next  = 1'b0;
                        w_loaded_next = 1'b0;
                        w_addr_next   = '0;
                        w_clear       = 1'b1;
                    end else if ((r_state == ST_IDLE) && r_loaded && (rx_data == c_CMD_RUN)) begin
                        w_state_next = ST_RUN;
                        w_mips_next  = 1'b1;
                    end else if ((r_state == ST_IDLE) && r_loaded && (rx_data == c_CMD_STEP)) begin
                        w_state_next = ST_STEP;
                        w_mips_next  = 1'b1;
                    end else begin
                        w_error_next = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (w_word_valid) begin
                    w_we_next      = 1'b1;
                    w_wr_addr_next = r_addr;
                    w_wr_data_next = w_word;
                    w_addr_next    = r_addr + LENGTH'(1);
                    // A halt in the last slot still counts as a complete program.
                    if (w_word == HALT_WORD) begin
                        w_state_next = ST_ARM;
                    end else if (r_addr == c_LAST_ADDR) begin
                        w_state_next  = ST_IDLE;
                        w_error_next  = 1'b1;
                        w_loaded_next = 1'b0;
                    end
                end
            end
            ST_ARM: begin
                w_start_next  = 1'b1;
                w_loaded_next = 1'b1;
                w_state_next  = ST_IDLE;
            end
            ST_RUN: begin
                if (halt_detected) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_mips_next = 1'b1;
                end
            end
            ST_STEP: begin
                w_state_next = halt_detected ? ST_DONE : ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_start   <= 1'b0;
            r_mips    <= 1'b0;
            r_loaded  <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_addr    <= w_addr_next;
            r_we      <= w_we_next;
            r_wr_addr <= w_wr_addr_next;
            r_wr_data <= w_wr_data_next;
            r_start   <= w_start_next;
            r_mips    <= w_mips_next;
            r_loaded  <= w_loaded_next;
            r_error   <= w_error_next;
        end
    end

    assign write_enable         = r_we;
    assign address_to_write     = r_wr_addr;
    assign instruction_to_write = r_wr_data;
    assign start                = r_start;
    assign mips_enable          = r_mips;
    assign loaded               = r_loaded;
    assign error                = r_error;
    assign state                = r_state;

endmodule
`default_nettype wire
